// File: rtl/mux8_sched_pkg.sv
// Shared types, widths and helpers for the round-robin 8:1 mux scheduler.
package mux8_sched_pkg;

    localparam int unsigned N      = 8;
    localparam int unsigned SEL_W  = 3;
    localparam int unsigned HOLD_W = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Next round-robin start index; 7 wraps to 0 through natural 3-bit overflow.
    function automatic logic [SEL_W-1:0] inc_mod8(input logic [SEL_W-1:0] v);
        return v + SEL_W'(1);
    endfunction

endpackage

// File: rtl/mux8to1.sv
// Existing 8:1 single-bit data multiplexer.
module mux8to1 (
    input  logic [7:0] a,
    input  logic [2:0] sel,
    output logic       y
);

    assign y = a[sel];

endmodule

// File: rtl/rr_pick8.sv
// Combinational round-robin picker: first set request at or after ptr (mod 8).
module rr_pick8
    import mux8_sched_pkg::*;
(
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic             any,
    output logic [SEL_W-1:0] idx,
    output logic [N-1:0]     onehot
);

    logic [N-1:0]     rot;
    logic [SEL_W-1:0] off;

    // Rotate so ptr lands at bit 0, then take the lowest set bit.
    always_comb begin
        rot = N'({req, req} >> ptr);
        off = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) off = SEL_W'(i);
        end
        any    = |req;
        idx    = ptr + off;
        onehot = N'(1) << idx;
    end

endmodule

// File: rtl/mux8_rr_sched.sv
// Round-robin scheduler time-sharing an 8:1 bit mux among eight requesters.
// Optional MUX8_LOCK_EN adds a per-requester lock that suspends MAX_HOLD rotation.
module mux8_rr_sched
    import mux8_sched_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic [7:0] a,
`ifdef MUX8_LOCK_EN
    input  logic [7:0] lock,
`endif
    output logic [2:0] sel,
    output logic [7:0] grant,
    output logic       out,
    output logic       out_vld
);

    localparam logic [HOLD_W-1:0] MAX_HOLD_C = HOLD_W'(MAX_HOLD);

    state_t            state_q, state_d;
    logic [N-1:0]      grant_q, grant_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [SEL_W-1:0]  ptr_q, ptr_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              out_q, out_d;
    logic              vld_q, vld_d;

    logic              pick_any;
    logic [SEL_W-1:0]  pick_idx;
    logic [N-1:0]      pick_onehot;
    logic              mux_y;
    logic              at_limit;
    logic [HOLD_W-1:0] hold_next;
    logic              limit_release;

    rr_pick8 u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .any    (pick_any),
        .idx    (pick_idx),
        .onehot (pick_onehot)
    );

    mux8to1 u_mux (
        .a   (a),
        .sel (sel_q),
        .y   (mux_y)
    );

    // This sample is the MAX_HOLD-th (or later, when clamped under lock).
    assign at_limit = (hold_q >= (MAX_HOLD_C - HOLD_W'(1)));

`ifdef MUX8_LOCK_EN
    assign hold_next     = (hold_q >= MAX_HOLD_C) ? MAX_HOLD_C : hold_q + HOLD_W'(1);
    assign limit_release = at_limit && !lock[sel_q];
`else
    assign hold_next     = hold_q + HOLD_W'(1);
    assign limit_release = at_limit;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
            out_q   <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            out_q   <= out_d;
            vld_q   <= vld_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        out_d   = out_q;
        vld_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    sel_d   = pick_idx;
                    grant_d = pick_onehot;
                    hold_d  = '0;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (req[sel_q]) begin
                    out_d  = mux_y;
                    vld_d  = 1'b1;
                    hold_d = hold_next;
                end
                // Dropped request releases at once; otherwise rotate at the hold limit.
                if (!req[sel_q] || limit_release) begin
                    grant_d = '0;
                    ptr_d   = inc_mod8(sel_q);
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    assign sel     = sel_q;
    assign grant   = grant_q;
    assign out     = out_q;
    assign out_vld = vld_q;

endmodule

// File: tb/tb_mux8_rr_sched.sv
// Scoreboard bench for mux8_rr_sched: expected outputs are queued per cycle and
// compared one edge later. Lock scenario runs only with MUX8_LOCK_EN.
module tb_mux8_rr_sched;

    typedef struct packed {
        logic [7:0] grant;
        logic [2:0] sel;
        logic       out;
        logic       vld;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] a;
    logic [2:0] sel;
    logic [7:0] grant;
    logic       out;
    logic       out_vld;
`ifdef MUX8_LOCK_EN
    logic [7:0] lock;
`endif

    exp_t exp_q[$];
    int   n_chk;
    int   n_fail;
    logic eo;

    mux8_rr_sched #(.MAX_HOLD(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .a       (a),
`ifdef MUX8_LOCK_EN
        .lock    (lock),
`endif
        .sel     (sel),
        .grant   (grant),
        .out     (out),
        .out_vld (out_vld)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic test_reset();
        exp_t e;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            req = 8'($urandom);
            a   = 8'($urandom);
            exp_q.push_back(exp_t'(13'd0));
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_chk++;
            if ({grant, sel, out, out_vld} !== e) begin
                n_fail++;
                $display("FAIL reset_hold k=%0d: got g=%h s=%0d o=%b v=%b, exp all zero", k, grant, sel, out, out_vld);
            end
        end
        req = 8'h00;
        @(negedge clk) rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            a = 8'($urandom);
            exp_q.push_back(exp_t'(13'd0));
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_chk++;
            if ({grant, sel, out, out_vld} !== e) begin
                n_fail++;
                $display("FAIL reset_idle k=%0d: got g=%h s=%0d o=%b v=%b, exp all zero", k, grant, sel, out, out_vld);
            end
        end
        eo = 1'b0;
    endtask

    // req 8'h42 from ptr 0: alternating grants to 1 and 6, four samples each.
    task automatic test_fairness();
        exp_t e;
        int   w;
        int   p;
        req = 8'h42;
        for (int k = 0; k < 21; k++) begin
            a = 8'($urandom);
            if (k == 20) begin
                req = 8'h00;
                e = {8'h00, 3'd6, eo, 1'b0};
            end else begin
                w = ((k / 5) % 2 == 1) ? 6 : 1;
                p = k % 5;
                if (p == 0) begin
                    e = {8'(1 << w), 3'(w), eo, 1'b0};
                end else begin
                    eo = a[w];
                    e = {(p == 4) ? 8'h00 : 8'(1 << w), 3'(w), eo, 1'b1};
                end
            end
            exp_q.push_back(e);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_chk++;
            if ({grant, sel, out, out_vld} !== e) begin
                n_fail++;
                $display("FAIL fairness k=%0d: got g=%h s=%0d o=%b v=%b, exp g=%h s=%0d o=%b v=%b",
                         k, grant, sel, out, out_vld, e.grant, e.sel, e.out, e.vld);
            end
        end
    endtask

    // ptr is 7: grant 7 first, drop it after two samples, then requester 0.
    task automatic test_wrap_drop();
        exp_t e;
        for (int k = 0; k < 10; k++) begin
            a   = 8'($urandom);
            req = (k < 3) ? 8'h81 : ((k < 9) ? 8'h01 : 8'h00);
            case (k)
                0:       e = {8'h80, 3'd7, eo, 1'b0};
                1, 2:    begin eo = a[7]; e = {8'h80, 3'd7, eo, 1'b1}; end
                3:       e = {8'h00, 3'd7, eo, 1'b0};
                4:       e = {8'h01, 3'd0, eo, 1'b0};
                5, 6, 7: begin eo = a[0]; e = {8'h01, 3'd0, eo, 1'b1}; end
                8:       begin eo = a[0]; e = {8'h00, 3'd0, eo, 1'b1}; end
                default: e = {8'h00, 3'd0, eo, 1'b0};
            endcase
            exp_q.push_back(e);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_chk++;
            if ({grant, sel, out, out_vld} !== e) begin
                n_fail++;
                $display("FAIL wrap_drop k=%0d: got g=%h s=%0d o=%b v=%b, exp g=%h s=%0d o=%b v=%b",
                         k, grant, sel, out, out_vld, e.grant, e.sel, e.out, e.vld);
            end
        end
    endtask

    // Sole requester 3 held: four samples, one bubble, re-grant via wrapped search.
    task automatic test_single_hog();
        exp_t e;
        int   p;
        req = 8'h08;
        for (int k = 0; k < 14; k++) begin
            a = 8'($urandom);
            if (k >= 12) begin
                req = 8'h00;
                e = {8'h00, 3'd3, eo, 1'b0};
            end else begin
                p = k % 5;
                if (p == 0) begin
                    e = {8'h08, 3'd3, eo, 1'b0};
                end else begin
                    eo = a[3];
                    e = {(p == 4) ? 8'h00 : 8'h08, 3'd3, eo, 1'b1};
                end
            end
            exp_q.push_back(e);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_chk++;
            if ({grant, sel, out, out_vld} !== e) begin
                n_fail++;
                $display("FAIL hog k=%0d: got g=%h s=%0d o=%b v=%b, exp g=%h s=%0d o=%b v=%b",
                         k, grant, sel, out, out_vld, e.grant, e.sel, e.out, e.vld);
            end
        end
    endtask

    // Reset during the second sample clears outputs without a clock; ptr restarts at 0.
    task automatic test_mid_reset();
        exp_t e;
        req = 8'h08;
        for (int k = 0; k < 3; k++) begin
            a = 8'($urandom);
            if (k == 0) e = {8'h08, 3'd3, eo, 1'b0};
            else begin eo = a[3]; e = {8'h08, 3'd3, eo, 1'b1}; end
            exp_q.push_back(e);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_chk++;
            if ({grant, sel, out, out_vld} !== e) begin
                n_fail++;
                $display("FAIL mid_pre k=%0d: got g=%h s=%0d o=%b v=%b, exp g=%h s=%0d o=%b v=%b",
                         k, grant, sel, out, out_vld, e.grant, e.sel, e.out, e.vld);
            end
        end
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({grant, sel, out, out_vld} !== 13'd0) begin
            n_fail++;
            $display("FAIL mid_async: got g=%h s=%0d o=%b v=%b, exp all zero", grant, sel, out, out_vld);
        end
        eo  = 1'b0;
        req = 8'h88;
        @(negedge clk) rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            a = 8'($urandom);
            if (k == 1) req = 8'h00;
            case (k)
                0:       e = {8'h08, 3'd3, eo, 1'b0};
                default: e = {8'h00, 3'd3, eo, 1'b0};
            endcase
            exp_q.push_back(e);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_chk++;
            if ({grant, sel, out, out_vld} !== e) begin
                n_fail++;
                $display("FAIL mid_post k=%0d: got g=%h s=%0d o=%b v=%b, exp g=%h s=%0d o=%b v=%b",
                         k, grant, sel, out, out_vld, e.grant, e.sel, e.out, e.vld);
            end
        end
    endtask

`ifdef MUX8_LOCK_EN
    // Locked requester 0 takes nine samples, releases on the sample after unlock.
    task automatic test_lock();
        exp_t e;
        rst_n = 1'b0;
        #2;
        @(negedge clk) rst_n = 1'b1;
        eo   = 1'b0;
        req  = 8'h11;
        lock = 8'h01;
        for (int k = 0; k < 13; k++) begin
            a = 8'($urandom);
            if (k == 10) lock = 8'h00;
            if (k == 12) req = 8'h00;
            if (k == 0) e = {8'h01, 3'd0, eo, 1'b0};
            else if (k < 10) begin eo = a[0]; e = {8'h01, 3'd0, eo, 1'b1}; end
            else if (k == 10) begin eo = a[0]; e = {8'h00, 3'd0, eo, 1'b1}; end
            else if (k == 11) e = {8'h10, 3'd4, eo, 1'b0};
            else e = {8'h00, 3'd4, eo, 1'b0};
            exp_q.push_back(e);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_chk++;
            if ({grant, sel, out, out_vld} !== e) begin
                n_fail++;
                $display("FAIL lock k=%0d: got g=%h s=%0d o=%b v=%b, exp g=%h s=%0d o=%b v=%b",
                         k, grant, sel, out, out_vld, e.grant, e.sel, e.out, e.vld);
            end
        end
    endtask
`endif

    initial begin
        n_chk  = 0;
        n_fail = 0;
        eo     = 1'b0;
        req    = 8'h00;
        a      = 8'h00;
`ifdef MUX8_LOCK_EN
        lock   = 8'h00;
`endif
        test_reset();
        test_fairness();
        test_wrap_drop();
        test_single_hog();
        test_mid_reset();
`ifdef MUX8_LOCK_EN
        test_lock();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
